// File: rtl/morty_pipe_pkg.sv
// Shared encodings for the Morty pipeline stall/flush sequencer.
//   PCSEL_*          : PC source select values
//   state_e          : sequencer states RUN / DWAIT / TRAP
//   EXC_NONE         : "no exception" code at the MEM stage
//   BUSERR_CODE_DEF  : default cause injected when the dmem watchdog expires
package morty_pipe_pkg;

  localparam int unsigned PCSEL_W = 2;

  localparam logic [PCSEL_W-1:0] PCSEL_SEQ  = 2'b00;
  localparam logic [PCSEL_W-1:0] PCSEL_BR   = 2'b01;
  localparam logic [PCSEL_W-1:0] PCSEL_TRAP = 2'b10;

  localparam int unsigned EXC_NONE        = 0;
  localparam int unsigned BUSERR_CODE_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

endpackage

// File: rtl/morty_hazard_detect.sv
// Load-use hazard compare between the ID/EX load and the IF/ID sources.
//   idex_mem_read : ID/EX instruction is a load
//   idex_rd       : ID/EX destination register
//   ifid_rs1/rs2  : IF/ID source registers
//   hazard_c      : combinational hazard flag (never set for rd = x0)
module morty_hazard_detect (
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rd,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  output logic       hazard_c
);

  always_comb begin
    hazard_c = idex_mem_read && (idex_rd != 5'd0) &&
               ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
  end

endmodule

// File: rtl/morty_pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage Morty pipeline.
// Arbitrates exceptions, dmem wait states (with watchdog), taken branches,
// load-use hazards and ifetch waits; drives PC and pipe-register controls.
// Ports:
//   clk, rst (sync, active-low)
//   imem_ready_i, dmem_req_i, dmem_ready_i, branch_taken_i
//   idex_mem_read_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i, exc_mem_i
//   stall_pc_o, pc_sel_o, stall_{ifid,idex,exmem,memwb}_o,
//   clear_{ifid,idex,exmem,memwb}_o, trap_cause_o
// Optional: define MORTY_PERF_CNT_EN to add stall_cnt_o / flush_cnt_o.
module morty_pipeline_ctrl
  import morty_pipe_pkg::*;
#(
  parameter int unsigned      DWAIT_MAX   = 16,
  parameter int unsigned      EXC_W       = 4,
  parameter logic [EXC_W-1:0] BUSERR_CODE = EXC_W'(BUSERR_CODE_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               imem_ready_i,
  input  logic               dmem_req_i,
  input  logic               dmem_ready_i,
  input  logic               branch_taken_i,
  input  logic               idex_mem_read_i,
  input  logic [4:0]         idex_rd_i,
  input  logic [4:0]         ifid_rs1_i,
  input  logic [4:0]         ifid_rs2_i,
  input  logic [EXC_W-1:0]   exc_mem_i,
  output logic               stall_pc_o,
  output logic [PCSEL_W-1:0] pc_sel_o,
  output logic               stall_ifid_o,
  output logic               stall_idex_o,
  output logic               stall_exmem_o,
  output logic               stall_memwb_o,
  output logic               clear_ifid_o,
  output logic               clear_idex_o,
  output logic               clear_exmem_o,
  output logic               clear_memwb_o,
`ifdef MORTY_PERF_CNT_EN
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        flush_cnt_o,
`endif
  output logic [EXC_W-1:0]   trap_cause_o
);

  localparam int unsigned WD_W = $clog2(DWAIT_MAX + 1);

  state_e           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [EXC_W-1:0] cause_d;
  logic             load_use_c;
  logic             run_flow_c;
  logic             exc_pending_c;

  morty_hazard_detect u_hazard (
    .idex_mem_read (idex_mem_read_i),
    .idex_rd       (idex_rd_i),
    .ifid_rs1      (ifid_rs1_i),
    .ifid_rs2      (ifid_rs2_i),
    .hazard_c      (load_use_c)
  );

  assign exc_pending_c = (exc_mem_i != EXC_W'(EXC_NONE));

  // State, watchdog and latched trap cause.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      wd_q         <= '0;
      trap_cause_o <= '0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      trap_cause_o <= cause_d;
    end
  end

  // Next state and pipeline control outputs.
  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    cause_d       = trap_cause_o;
    run_flow_c    = 1'b0;
    stall_pc_o    = 1'b0;
    pc_sel_o      = PCSEL_SEQ;
    stall_ifid_o  = 1'b0;
    stall_idex_o  = 1'b0;
    stall_exmem_o = 1'b0;
    stall_memwb_o = 1'b0;
    clear_ifid_o  = 1'b0;
    clear_idex_o  = 1'b0;
    clear_exmem_o = 1'b0;
    clear_memwb_o = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (exc_pending_c) begin
          stall_pc_o    = 1'b1;
          clear_ifid_o  = 1'b1;
          clear_idex_o  = 1'b1;
          clear_exmem_o = 1'b1;
          cause_d       = exc_mem_i;
          state_d       = ST_TRAP;
        end else if (dmem_req_i && !dmem_ready_i) begin
          stall_pc_o    = 1'b1;
          stall_ifid_o  = 1'b1;
          stall_idex_o  = 1'b1;
          stall_exmem_o = 1'b1;
          clear_memwb_o = 1'b1;
          wd_d          = WD_W'(1);
          state_d       = ST_DWAIT;
        end else begin
          run_flow_c = 1'b1;
        end
      end
      ST_DWAIT: begin
        // MEM is frozen here, so a pending exception is picked up back in RUN.
        if (dmem_ready_i) begin
          wd_d       = '0;
          state_d    = ST_RUN;
          run_flow_c = 1'b1;
        end else if (wd_q == WD_W'(DWAIT_MAX)) begin
          stall_pc_o    = 1'b1;
          clear_ifid_o  = 1'b1;
          clear_idex_o  = 1'b1;
          clear_exmem_o = 1'b1;
          cause_d       = BUSERR_CODE;
          wd_d          = '0;
          state_d       = ST_TRAP;
        end else begin
          stall_pc_o    = 1'b1;
          stall_ifid_o  = 1'b1;
          stall_idex_o  = 1'b1;
          stall_exmem_o = 1'b1;
          clear_memwb_o = 1'b1;
          wd_d          = wd_q + WD_W'(1);
        end
      end
      ST_TRAP: begin
        // MEM/WB keeps flowing so the trapping instruction reaches WB.
        pc_sel_o      = PCSEL_TRAP;
        clear_ifid_o  = 1'b1;
        clear_idex_o  = 1'b1;
        clear_exmem_o = 1'b1;
        state_d       = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        wd_d    = '0;
      end
    endcase

    // Lower-priority hazards, shared by RUN and the DWAIT release cycle.
    if (run_flow_c) begin
      if (branch_taken_i) begin
        pc_sel_o     = PCSEL_BR;
        clear_ifid_o = 1'b1;
        clear_idex_o = 1'b1;
      end else if (load_use_c) begin
        stall_pc_o   = 1'b1;
        stall_ifid_o = 1'b1;
        clear_idex_o = 1'b1;
      end else if (!imem_ready_i) begin
        stall_pc_o   = 1'b1;
        clear_ifid_o = 1'b1;
      end
    end

    if (!rst) begin
      stall_pc_o    = 1'b1;
      pc_sel_o      = PCSEL_SEQ;
      stall_ifid_o  = 1'b0;
      stall_idex_o  = 1'b0;
      stall_exmem_o = 1'b0;
      stall_memwb_o = 1'b0;
      clear_ifid_o  = 1'b1;
      clear_idex_o  = 1'b1;
      clear_exmem_o = 1'b1;
      clear_memwb_o = 1'b1;
    end
  end

`ifdef MORTY_PERF_CNT_EN
  logic flush_evt_c;

  assign flush_evt_c = rst && ((pc_sel_o == PCSEL_BR) || (state_d == ST_TRAP));

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_pc_o)  stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_evt_c) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_morty_pipeline_ctrl.sv
// Directed, table-driven bench for morty_pipeline_ctrl.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_morty_pipeline_ctrl;

  localparam int unsigned EXC_W = 4;

  // {stall_pc, pc_sel[1:0], stall_ifid, stall_idex, stall_exmem, stall_memwb,
  //  clear_ifid, clear_idex, clear_exmem, clear_memwb}
  localparam logic [10:0] P_IDLE  = 11'b0_00_0000_0000;
  localparam logic [10:0] P_BR    = 11'b0_01_0000_1100;
  localparam logic [10:0] P_LU    = 11'b1_00_1000_0100;
  localparam logic [10:0] P_IMISS = 11'b1_00_0000_1000;
  localparam logic [10:0] P_DSTL  = 11'b1_00_1110_0001;
  localparam logic [10:0] P_EXC   = 11'b1_00_0000_1110;
  localparam logic [10:0] P_TRAP  = 11'b0_10_0000_1110;
  localparam logic [10:0] P_RST   = 11'b1_00_0000_1111;

  logic             clk;
  logic             rst;
  logic             imem_ready_i, dmem_req_i, dmem_ready_i, branch_taken_i;
  logic             idex_mem_read_i;
  logic [4:0]       idex_rd_i, ifid_rs1_i, ifid_rs2_i;
  logic [EXC_W-1:0] exc_mem_i;
  logic             stall_pc_o;
  logic [1:0]       pc_sel_o;
  logic             stall_ifid_o, stall_idex_o, stall_exmem_o, stall_memwb_o;
  logic             clear_ifid_o, clear_idex_o, clear_exmem_o, clear_memwb_o;
  logic [EXC_W-1:0] trap_cause_o;
`ifdef MORTY_PERF_CNT_EN
  logic [31:0]      stall_cnt_o, flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  morty_pipeline_ctrl #(.DWAIT_MAX(16), .EXC_W(EXC_W), .BUSERR_CODE(4'd5)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_ready_i    (imem_ready_i),
    .dmem_req_i      (dmem_req_i),
    .dmem_ready_i    (dmem_ready_i),
    .branch_taken_i  (branch_taken_i),
    .idex_mem_read_i (idex_mem_read_i),
    .idex_rd_i       (idex_rd_i),
    .ifid_rs1_i      (ifid_rs1_i),
    .ifid_rs2_i      (ifid_rs2_i),
    .exc_mem_i       (exc_mem_i),
    .stall_pc_o      (stall_pc_o),
    .pc_sel_o        (pc_sel_o),
    .stall_ifid_o    (stall_ifid_o),
    .stall_idex_o    (stall_idex_o),
    .stall_exmem_o   (stall_exmem_o),
    .stall_memwb_o   (stall_memwb_o),
    .clear_ifid_o    (clear_ifid_o),
    .clear_idex_o    (clear_idex_o),
    .clear_exmem_o   (clear_exmem_o),
    .clear_memwb_o   (clear_memwb_o),
`ifdef MORTY_PERF_CNT_EN
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o),
`endif
    .trap_cause_o    (trap_cause_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        imem;
    logic        dreq;
    logic        drdy;
    logic        br;
    logic        mr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [10:0] outs();
    return {stall_pc_o, pc_sel_o, stall_ifid_o, stall_idex_o, stall_exmem_o,
            stall_memwb_o, clear_ifid_o, clear_idex_o, clear_exmem_o, clear_memwb_o};
  endfunction

  task automatic idle_in();
    rst             = 1'b1;
    imem_ready_i    = 1'b1;
    dmem_req_i      = 1'b0;
    dmem_ready_i    = 1'b0;
    branch_taken_i  = 1'b0;
    idex_mem_read_i = 1'b0;
    idex_rd_i       = 5'd0;
    ifid_rs1_i      = 5'd0;
    ifid_rs2_i      = 5'd0;
    exc_mem_i       = '0;
  endtask

  // Sample outputs for the current cycle, then advance to the next falling edge.
  task automatic cyc(input string name, input logic [10:0] exp);
    logic [10:0] got;
    #1;
    got = outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
    @(negedge clk);
  endtask

  task automatic chk_cause(input string name, input logic [EXC_W-1:0] exp);
    checks++;
    if (trap_cause_o !== exp) begin
      errors++;
      $display("FAIL %s: trap_cause got %0d expected %0d", name, trap_cause_o, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{"idle",         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  P_IDLE};
    vecs[1]  = '{"imiss",        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  P_IMISS};
    vecs[2]  = '{"lu_rs1",       1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  5'd5,  5'd0,  P_LU};
    vecs[3]  = '{"lu_gone",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5,  5'd5,  5'd0,  P_IDLE};
    vecs[4]  = '{"lu_x0",        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  P_IDLE};
    vecs[5]  = '{"lu_rs2",       1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  5'd3,  5'd7,  P_LU};
    vecs[6]  = '{"br_over_lu",   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  5'd5,  5'd0,  P_BR};
    vecs[7]  = '{"lu_over_imiss",1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9,  5'd9,  5'd1,  P_LU};
    vecs[8]  = '{"br_over_imiss",1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  P_BR};
    vecs[9]  = '{"lu_nomatch",   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  5'd6,  5'd7,  P_IDLE};
    vecs[10] = '{"lu_r31",       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 5'd2,  5'd31, P_LU};
    vecs[11] = '{"dmem_hit",     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  P_IDLE};

    idle_in();
    rst = 1'b0;
    branch_taken_i = 1'b1;
    @(negedge clk);
    cyc("reset_forced", P_RST);
    idle_in();
    rst = 1'b0;
    cyc("reset_hold", P_RST);
    idle_in();
    #1 chk_cause("reset_cause", 4'd0);

    // Single-cycle RUN vectors.
    for (int i = 0; i < 12; i++) begin
      idle_in();
      imem_ready_i    = vecs[i].imem;
      dmem_req_i      = vecs[i].dreq;
      dmem_ready_i    = vecs[i].drdy;
      branch_taken_i  = vecs[i].br;
      idex_mem_read_i = vecs[i].mr;
      idex_rd_i       = vecs[i].rd;
      ifid_rs1_i      = vecs[i].rs1;
      ifid_rs2_i      = vecs[i].rs2;
      cyc(vecs[i].name, vecs[i].exp);
    end

    // dmem wait for 3 cycles, released on ready.
    idle_in();
    dmem_req_i = 1'b1;
    for (int i = 0; i < 3; i++) cyc("dwait3", P_DSTL);
    dmem_ready_i = 1'b1;
    cyc("dwait3_release", P_IDLE);
    idle_in();
    cyc("dwait3_after", P_IDLE);

    // Release cycle re-evaluates a taken branch.
    dmem_req_i = 1'b1;
    cyc("dwait_br_stall", P_DSTL);
    dmem_ready_i   = 1'b1;
    branch_taken_i = 1'b1;
    cyc("dwait_br_release", P_BR);
    idle_in();

    // Watchdog expiry: 16 stall cycles, 1 trap-flush cycle, 1 TRAP cycle.
    dmem_req_i = 1'b1;
    for (int i = 0; i < 16; i++) cyc("wd_stall", P_DSTL);
    cyc("wd_expire", P_EXC);
    #1 chk_cause("wd_cause", 4'd5);
    cyc("wd_trap", P_TRAP);
    idle_in();
    cyc("wd_after", P_IDLE);

    // Ready on the expiry cycle wins over the watchdog.
    dmem_req_i = 1'b1;
    for (int i = 0; i < 16; i++) cyc("wd_race_stall", P_DSTL);
    dmem_ready_i = 1'b1;
    cyc("wd_race_release", P_IDLE);
    idle_in();
    cyc("wd_race_no_trap", P_IDLE);

    // Exception beats a simultaneous branch.
    exc_mem_i      = 4'd2;
    branch_taken_i = 1'b1;
    cyc("exc_vs_br", P_EXC);
    idle_in();
    #1 chk_cause("exc_cause", 4'd2);
    cyc("exc_trap", P_TRAP);
    cyc("exc_after", P_IDLE);

    // Exception during DWAIT is deferred until the transfer completes.
    dmem_req_i = 1'b1;
    cyc("dexc_stall", P_DSTL);
    exc_mem_i = 4'd3;
    cyc("dexc_ignored", P_DSTL);
    dmem_ready_i = 1'b1;
    cyc("dexc_release", P_IDLE);
    dmem_req_i   = 1'b0;
    dmem_ready_i = 1'b0;
    cyc("dexc_taken", P_EXC);
    idle_in();
    #1 chk_cause("dexc_cause", 4'd3);
    cyc("dexc_trap", P_TRAP);

    // Reset in the middle of DWAIT.
    dmem_req_i = 1'b1;
    cyc("rst_dwait_stall", P_DSTL);
    cyc("rst_dwait_stall2", P_DSTL);
    rst = 1'b0;
    cyc("rst_mid_dwait", P_RST);
    idle_in();
    #1 chk_cause("rst_mid_cause", 4'd0);
    cyc("rst_mid_fetch", P_IDLE);
    // Back in RUN with a cleared watchdog: a new miss stalls, then expires on time.
    dmem_req_i = 1'b1;
    for (int i = 0; i < 16; i++) cyc("rst_wd_stall", P_DSTL);
    cyc("rst_wd_expire", P_EXC);
    idle_in();
    cyc("rst_wd_trap", P_TRAP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morty_pipeline_ctrl.md
Name: morty_pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage Morty pipeline. It drives the stall_* and clear_* inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and drives PC write-enable and PC source select. It arbitrates between exceptions, data-memory wait states, taken branches, load-use hazards and instruction-fetch waits. A small FSM with a wait-state watchdog handles the multi-cycle cases.

Parameters:
DWAIT_MAX, 16, max consecutive dmem wait cycles before a bus-error trap is raised (>=2)
EXC_W, 4, width of exception code carried down the pipe
BUSERR_CODE, 4'd5, exception code injected on watchdog expiry

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous reset, active-low
imem_ready_i  in  1  instruction fetch data valid this cycle
dmem_req_i  in  1  MEM stage has a load/store outstanding
dmem_ready_i  in  1  data memory completes this cycle
branch_taken_i  in  1  EX stage resolved a taken branch/jump
idex_mem_read_i  in  1  instruction in ID/EX is a load
idex_rd_i  in  5  destination of ID/EX instruction
ifid_rs1_i  in  5  rs1 of IF/ID instruction
ifid_rs2_i  in  5  rs2 of IF/ID instruction
exc_mem_i  in  EXC_W  exception code at MEM stage; 0 = none
stall_pc_o  out  1  hold PC
pc_sel_o  out  2  PC source: 00 PC+4, 01 branch target, 10 trap vector, 11 reserved
stall_ifid_o, stall_idex_o, stall_exmem_o, stall_memwb_o  out  1 each  hold register
clear_ifid_o, clear_idex_o, clear_exmem_o, clear_memwb_o  out  1 each  bubble register
trap_cause_o  out  EXC_W  latched cause, valid while state==TRAP

Behaviour:
- Reset: rst==0 sampled at posedge -> state RUN, watchdog=0, trap_cause_o=0. While rst==0, outputs are forced: all clear_*=1, all stall_*=0, stall_pc_o=1, pc_sel_o=00.
- Outputs are combinational from state plus inputs. State, watchdog and trap_cause_o are registered.
- States: RUN, DWAIT, TRAP.
- RUN, priority high->low:
  1. exc_mem_i!=0 -> clear_ifid/idex/exmem=1, stall_pc=1; latch trap_cause=exc_mem_i; next TRAP.
  2. dmem_req_i & !dmem_ready_i -> stall_pc/ifid/idex/exmem=1, clear_memwb=1; watchdog=1; next DWAIT.
  3. branch_taken_i -> pc_sel=01, clear_ifid=1, clear_idex=1.
  4. load-use (idex_mem_read_i & idex_rd_i!=0 & (idex_rd_i==ifid_rs1_i | idex_rd_i==ifid_rs2_i)) -> stall_pc=1, stall_ifid=1, clear_idex=1.
  5. !imem_ready_i -> stall_pc=1, clear_ifid=1.
  6. Otherwise all 0, pc_sel=00.
- DWAIT:
  - Same stall/clear pattern as RUN item 2 while !dmem_ready_i; watchdog++.
  - dmem_ready_i -> release all, next RUN, watchdog=0. Branch/load-use are re-evaluated the same cycle, as in RUN items 3-6.
  - watchdog==DWAIT_MAX & !dmem_ready_i -> trap_cause=BUSERR_CODE, clear_ifid/idex/exmem=1, next TRAP.
  - dmem_ready_i on the same cycle as expiry wins: no trap.
- TRAP (exactly 1 cycle): pc_sel=10, clear_memwb=0 (the trapping instruction reaches WB for CSR update), clear_ifid/idex/exmem=1; next RUN.
- exc_mem_i arriving during DWAIT is ignored until the transfer completes; the MEM stage is frozen, so it is seen again in RUN.
- Stall and clear are never both asserted on the same register.
- Load-use against rd=x0 never stalls.

Optional Feature:
MORTY_PERF_CNT_EN
- Defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments every cycle stall_pc_o=1 outside reset.
  - flush_cnt_o increments on each branch flush or TRAP entry.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: ports and logic are absent.

Decomposition:
- Package morty_pipe_pkg holds:
  - pc_sel encodings PCSEL_SEQ/PCSEL_BR/PCSEL_TRAP
  - state enum for RUN/DWAIT/TRAP
  - EXC_NONE=0
  - BUSERR_CODE default
- One sub-module, morty_hazard_detect: combinational load-use compare producing a single hazard bit.

Test Plan:
- idex_mem_read=1, idex_rd=5, ifid_rs1=5 -> one cycle with stall_pc=stall_ifid=clear_idex=1; next cycle, with idex_mem_read=0, all 0.
- Same case with idex_rd=0 -> no stall.
- dmem_req=1 with dmem_ready low 3 cycles -> stall_exmem=1 and clear_memwb=1 for 3 cycles; release on the cycle ready=1.
- dmem_ready never rises, DWAIT_MAX=16 -> TRAP entered with trap_cause=5 and pc_sel=10 for exactly 1 cycle.
- exc_mem=4'd2 and branch_taken=1 in the same cycle -> exception wins: clear_ifid/idex/exmem=1, next cycle pc_sel=10, trap_cause=2.
- rst driven low mid-DWAIT -> next cycle state RUN, all clear=1, watchdog=0; after rst=1, normal fetch with pc_sel=00.
